// File: rtl/ctrl_pipe_regs.sv
// Consumer end of the control-unit bundle: carries decoded control bits through the
// EX/MEM/WB pipeline registers with load-use bubbles, branch flush, global hold and a stall counter.
module ctrl_pipe_regs #(
    parameter int ALUOP_W = 1,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_RegDst,
    input  logic               id_Branch,
    input  logic               id_MemtoReg,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_ALUSrc,
    input  logic               id_RegWrite,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               hold_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               ex_RegDst,
    output logic               ex_ALUSrc,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [REG_AW-1:0]  ex_wreg,
    output logic               mem_Branch,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic [REG_AW-1:0]  mem_wreg,
    output logic               wb_MemtoReg,
    output logic               wb_RegWrite,
    output logic [REG_AW-1:0]  wb_wreg,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef struct packed {
        logic               valid;
        logic               regDst;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
        logic               branch;
        logic               memRead;
        logic               memWrite;
        logic               memtoReg;
        logic               regWrite;
        logic [REG_AW-1:0]  wreg;
    } exStage_t;

    typedef struct packed {
        logic              valid;
        logic              branch;
        logic              memRead;
        logic              memWrite;
        logic              memtoReg;
        logic              regWrite;
        logic [REG_AW-1:0] wreg;
    } memStage_t;

    typedef struct packed {
        logic              valid;
        logic              memtoReg;
        logic              regWrite;
        logic [REG_AW-1:0] wreg;
    } wbStage_t;

    exStage_t         exQ;
    exStage_t         idEntry;
    memStage_t        memQ;
    memStage_t        exToMem;
    wbStage_t         wbQ;
    wbStage_t         memToWb;
    logic [CNT_W-1:0] stallCnt;
    logic             hazard;

    always_comb begin
        // NOTE: default first, so no path leaves idEntry unassigned and infers a latch.
        idEntry = '0;
        if (id_valid) begin
            idEntry.valid    = 1'b1;
            idEntry.regDst   = id_RegDst;
            idEntry.aluSrc   = id_ALUSrc;
            idEntry.aluOp    = id_ALUOp;
            idEntry.branch   = id_Branch;
            idEntry.memRead  = id_MemRead;
            idEntry.memWrite = id_MemWrite;
            idEntry.memtoReg = id_MemtoReg;
            idEntry.regWrite = id_RegWrite;
            idEntry.wreg     = id_RegDst ? id_rd : id_rt;
        end
    end

    // Downstream stages keep only the control bits still needed; bubbles are all-zero already.
    always_comb begin
        exToMem          = '0;
        exToMem.valid    = exQ.valid;
        exToMem.branch   = exQ.branch;
        exToMem.memRead  = exQ.memRead;
        exToMem.memWrite = exQ.memWrite;
        exToMem.memtoReg = exQ.memtoReg;
        exToMem.regWrite = exQ.regWrite;
        exToMem.wreg     = exQ.wreg;

        memToWb          = '0;
        memToWb.valid    = memQ.valid;
        memToWb.memtoReg = memQ.memtoReg;
        memToWb.regWrite = memQ.regWrite;
        memToWb.wreg     = memQ.wreg;
    end

    // A load writing $0 never produces a real dependency, so it cannot stall.
    assign hazard = exQ.valid & exQ.memRead & (exQ.wreg != '0) & id_valid
                  & ((exQ.wreg == id_rs) | (exQ.wreg == id_rt));

    assign stall_o = hazard & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: stage registers are control state and must reset, or garbage would look like live instructions.
        if (!rst_n) begin
            exQ      <= '0;
            memQ     <= '0;
            wbQ      <= '0;
            stallCnt <= '0;
        end else if (!hold_i) begin
            // NOTE: non-blocking, so each stage captures the pre-edge value of the stage above it.
            if (flush_i) begin
                exQ  <= '0;
                memQ <= '0;
                wbQ  <= memToWb;
            end else if (hazard) begin
                exQ  <= '0;
                memQ <= exToMem;
                wbQ  <= memToWb;
                if (stallCnt != '1) begin
                    stallCnt <= stallCnt + 1'b1;
                end
            end else begin
                exQ  <= idEntry;
                memQ <= exToMem;
                wbQ  <= memToWb;
            end
        end
    end

    // Gating by valid keeps a stray bit in a bubble from ever reaching the datapath.
    assign ex_RegDst    = exQ.valid & exQ.regDst;
    assign ex_ALUSrc    = exQ.valid & exQ.aluSrc;
    assign ex_ALUOp     = {ALUOP_W{exQ.valid}} & exQ.aluOp;
    assign ex_wreg      = exQ.wreg;
    assign mem_Branch   = memQ.valid & memQ.branch;
    assign mem_MemRead  = memQ.valid & memQ.memRead;
    assign mem_MemWrite = memQ.valid & memQ.memWrite;
    assign mem_wreg     = memQ.wreg;
    assign wb_MemtoReg  = wbQ.valid & wbQ.memtoReg;
    assign wb_RegWrite  = wbQ.valid & wbQ.regWrite;
    assign wb_wreg      = wbQ.wreg;
    assign stall_cnt    = stallCnt;

    bubbleQuiet: assert property (@(posedge clk) disable iff (!rst_n)
        !exQ.valid |-> !(exQ.branch | exQ.memRead | exQ.memWrite | exQ.regWrite));

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Scoreboard bench for ctrl_pipe_regs: a directed row table feeds a queue of expected stage
// occupancy; a negedge monitor compares two instances (16-bit and 2-bit stall counters).
module tb_ctrl_pipe_regs;

    typedef struct packed {
        logic       valid;
        logic       regDst;
        logic       branch;
        logic       memtoReg;
        logic [0:0] aluOp;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] dst;
    } instr_t;

    // One cycle: inputs applied, then the hand-worked stage contents visible in that cycle.
    typedef struct packed {
        logic [3:0] id;
        logic       hold;
        logic       flush;
        logic       rst;
        logic       stall;
        logic [3:0] ex;
        logic [3:0] mem;
        logic [3:0] wb;
        logic [7:0] cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        id_RegDst, id_Branch, id_MemtoReg, id_MemRead, id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [0:0]  id_ALUOp;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        hold_i, flush_i;

    logic        stall_o, ex_RegDst, ex_ALUSrc, mem_Branch, mem_MemRead, mem_MemWrite;
    logic        wb_MemtoReg, wb_RegWrite;
    logic [0:0]  ex_ALUOp;
    logic [4:0]  ex_wreg, mem_wreg, wb_wreg;
    logic [15:0] stall_cnt;

    logic        satStall, satExRegDst, satExALUSrc, satMemBranch, satMemMemRead, satMemMemWrite;
    logic        satWbMemtoReg, satWbRegWrite;
    logic [0:0]  satExALUOp;
    logic [4:0]  satExWreg, satMemWreg, satWbWreg;
    logic [1:0]  satCnt;

    logic [7:0]  mainEx, mainMem, satEx, satMem;
    logic [6:0]  mainWb, satWb;

    vec_t        expQ [$];
    vec_t        rows [$];
    int          errors = 0;
    int          checks = 0;

    ctrl_pipe_regs #(.ALUOP_W(1), .REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_RegDst(id_RegDst), .id_Branch(id_Branch), .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_RegWrite(id_RegWrite), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .hold_i(hold_i), .flush_i(flush_i), .stall_o(stall_o),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_wreg(ex_wreg),
        .mem_Branch(mem_Branch), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_wreg(mem_wreg), .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
        .wb_wreg(wb_wreg), .stall_cnt(stall_cnt)
    );

    // Same stimulus with a 2-bit counter: 2 plays the role of 16'hFFFE, 3 of 16'hFFFF.
    ctrl_pipe_regs #(.ALUOP_W(1), .REG_AW(5), .CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n),
        .id_RegDst(id_RegDst), .id_Branch(id_Branch), .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_RegWrite(id_RegWrite), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .hold_i(hold_i), .flush_i(flush_i), .stall_o(satStall),
        .ex_RegDst(satExRegDst), .ex_ALUSrc(satExALUSrc), .ex_ALUOp(satExALUOp), .ex_wreg(satExWreg),
        .mem_Branch(satMemBranch), .mem_MemRead(satMemMemRead), .mem_MemWrite(satMemMemWrite),
        .mem_wreg(satMemWreg), .wb_MemtoReg(satWbMemtoReg), .wb_RegWrite(satWbRegWrite),
        .wb_wreg(satWbWreg), .stall_cnt(satCnt)
    );

    assign mainEx  = {ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_wreg};
    assign mainMem = {mem_Branch, mem_MemRead, mem_MemWrite, mem_wreg};
    assign mainWb  = {wb_MemtoReg, wb_RegWrite, wb_wreg};
    assign satEx   = {satExRegDst, satExALUSrc, satExALUOp, satExWreg};
    assign satMem  = {satMemBranch, satMemMemRead, satMemMemWrite, satMemWreg};
    assign satWb   = {satWbMemtoReg, satWbRegWrite, satWbWreg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mkI(int v, int regDst, int br, int m2r, int aluOp, int mr, int mw,
                                   int aluSrc, int rw, int rs, int rt, int rd, int dst);
        instr_t i;
        i.valid    = (v != 0);
        i.regDst   = (regDst != 0);
        i.branch   = (br != 0);
        i.memtoReg = (m2r != 0);
        i.aluOp    = 1'(aluOp);
        i.memRead  = (mr != 0);
        i.memWrite = (mw != 0);
        i.aluSrc   = (aluSrc != 0);
        i.regWrite = (rw != 0);
        i.rs       = 5'(rs);
        i.rt       = 5'(rt);
        i.rd       = 5'(rd);
        i.dst      = 5'(dst);
        return i;
    endfunction

    // dst is the hand-worked destination register for each instruction.
    function automatic instr_t instrOf(logic [3:0] tag);
        case (tag)
            4'd1:    return mkI(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 2, 3, 3);  // R-type -> $3
            4'd2:    return mkI(1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 5, 0, 5);  // lw -> $5
            4'd3:    return mkI(1, 1, 0, 0, 1, 0, 0, 0, 1, 5, 6, 7, 7);  // add uses $5 -> $7
            4'd4:    return mkI(1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0);  // lw -> $0
            4'd5:    return mkI(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2, 8, 8);  // user of $0 -> $8
            4'd6:    return mkI(1, 0, 1, 0, 1, 0, 0, 0, 0, 2, 3, 0, 3);  // beq, wreg = rt
            4'd7:    return mkI(1, 0, 0, 0, 0, 0, 1, 1, 0, 4, 9, 0, 9);  // sw
            4'd8:    return mkI(1, 0, 0, 1, 0, 1, 0, 1, 1, 5, 5, 0, 5);  // lw $5 from ($5)
            4'd9:    return mkI(0, 1, 0, 0, 1, 1, 0, 0, 1, 5, 5, 7, 7);  // invalid, bits set
            default: return mkI(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic logic [7:0] expEx(logic [3:0] tag);
        instr_t i = instrOf(tag);
        return {i.regDst, i.aluSrc, i.aluOp, i.dst};
    endfunction

    function automatic logic [7:0] expMem(logic [3:0] tag);
        instr_t i = instrOf(tag);
        return {i.branch, i.memRead, i.memWrite, i.dst};
    endfunction

    function automatic logic [6:0] expWb(logic [3:0] tag);
        instr_t i = instrOf(tag);
        return {i.memtoReg, i.regWrite, i.dst};
    endfunction

    function automatic vec_t mkV(int id, int hold, int flush, int rst, int stall,
                                 int ex, int mem, int wb, int cnt);
        vec_t v;
        v.id    = 4'(id);
        v.hold  = (hold != 0);
        v.flush = (flush != 0);
        v.rst   = (rst != 0);
        v.stall = (stall != 0);
        v.ex    = 4'(ex);
        v.mem   = 4'(mem);
        v.wb    = 4'(wb);
        v.cnt   = 8'(cnt);
        return v;
    endfunction

    task automatic check(string name, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic applyId(logic [3:0] tag);
        instr_t i = instrOf(tag);
        id_valid    = i.valid;
        id_RegDst   = i.regDst;
        id_Branch   = i.branch;
        id_MemtoReg = i.memtoReg;
        id_ALUOp    = i.aluOp;
        id_MemRead  = i.memRead;
        id_MemWrite = i.memWrite;
        id_ALUSrc   = i.aluSrc;
        id_RegWrite = i.regWrite;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_rd       = i.rd;
    endtask

    initial begin : monitor
        vec_t e;
        int   rowNum;
        int   satExp;
        rowNum = 0;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                satExp = (e.cnt > 8'd3) ? 3 : int'(e.cnt);
                check("stall",     rowNum, 32'(stall_o),   32'(e.stall));
                check("ex",        rowNum, 32'(mainEx),    32'(expEx(e.ex)));
                check("mem",       rowNum, 32'(mainMem),   32'(expMem(e.mem)));
                check("wb",        rowNum, 32'(mainWb),    32'(expWb(e.wb)));
                check("stall_cnt", rowNum, 32'(stall_cnt), 32'(e.cnt));
                check("sat_stall", rowNum, 32'(satStall),  32'(e.stall));
                check("sat_ex",    rowNum, 32'(satEx),     32'(expEx(e.ex)));
                check("sat_mem",   rowNum, 32'(satMem),    32'(expMem(e.mem)));
                check("sat_wb",    rowNum, 32'(satWb),     32'(expWb(e.wb)));
                check("sat_cnt",   rowNum, 32'(satCnt),    32'(satExp));
                rowNum++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst_n   = 1'b0;
        hold_i  = 1'b0;
        flush_i = 1'b0;
        applyId(4'd0);

        //              id hold flush rst stall ex mem wb cnt
        rows.push_back(mkV(2, 0, 0, 1, 0, 0, 0, 0, 0));  // reset held, lw on ID
        rows.push_back(mkV(1, 0, 0, 0, 0, 0, 0, 0, 0));  // straight flow: R-type
        rows.push_back(mkV(0, 0, 0, 0, 0, 1, 0, 0, 0));
        rows.push_back(mkV(0, 0, 0, 0, 0, 0, 1, 0, 0));
        rows.push_back(mkV(0, 0, 0, 0, 0, 0, 0, 1, 0));
        rows.push_back(mkV(2, 0, 0, 0, 0, 0, 0, 0, 0));  // load-use
        rows.push_back(mkV(3, 0, 0, 0, 1, 2, 0, 0, 0));
        rows.push_back(mkV(3, 0, 0, 0, 0, 0, 2, 0, 1));
        rows.push_back(mkV(0, 0, 0, 0, 0, 3, 0, 2, 1));
        rows.push_back(mkV(4, 0, 0, 0, 0, 0, 3, 0, 1));  // load to $0
        rows.push_back(mkV(5, 0, 0, 0, 0, 4, 0, 3, 1));
        rows.push_back(mkV(0, 0, 0, 0, 0, 5, 4, 0, 1));
        rows.push_back(mkV(6, 0, 0, 0, 0, 0, 5, 4, 1));  // flush vs hazard
        rows.push_back(mkV(2, 0, 0, 0, 0, 6, 0, 5, 1));
        rows.push_back(mkV(3, 0, 1, 0, 0, 2, 6, 0, 1));
        rows.push_back(mkV(1, 0, 0, 0, 0, 0, 0, 6, 1));
        rows.push_back(mkV(2, 0, 0, 0, 0, 1, 0, 0, 1));  // hold with pending hazard
        rows.push_back(mkV(3, 1, 0, 0, 1, 2, 1, 0, 1));
        rows.push_back(mkV(3, 1, 1, 0, 0, 2, 1, 0, 1));
        rows.push_back(mkV(3, 1, 0, 0, 1, 2, 1, 0, 1));
        rows.push_back(mkV(3, 0, 0, 0, 1, 2, 1, 0, 1));
        rows.push_back(mkV(3, 0, 0, 0, 0, 0, 2, 1, 2));
        rows.push_back(mkV(7, 0, 0, 0, 0, 3, 0, 2, 2));
        rows.push_back(mkV(0, 0, 0, 0, 0, 7, 3, 0, 2));
        rows.push_back(mkV(0, 0, 0, 0, 0, 0, 7, 3, 2));
        rows.push_back(mkV(0, 0, 0, 0, 0, 0, 0, 7, 2));
        rows.push_back(mkV(8, 0, 0, 0, 0, 0, 0, 0, 2));  // repeated self-dependent loads
        rows.push_back(mkV(8, 0, 0, 0, 1, 8, 0, 0, 2));
        rows.push_back(mkV(8, 0, 0, 0, 0, 0, 8, 0, 3));
        rows.push_back(mkV(8, 0, 0, 0, 1, 8, 0, 8, 3));
        rows.push_back(mkV(8, 0, 0, 0, 0, 0, 8, 0, 4));
        rows.push_back(mkV(8, 0, 0, 0, 1, 8, 0, 8, 4));
        rows.push_back(mkV(0, 0, 0, 0, 0, 0, 8, 0, 5));
        rows.push_back(mkV(0, 0, 0, 1, 0, 0, 0, 0, 0));  // async reset mid-cycle, WB was busy
        rows.push_back(mkV(2, 0, 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(mkV(9, 0, 0, 0, 0, 2, 0, 0, 0));  // invalid ID never stalls or enters
        rows.push_back(mkV(0, 0, 0, 0, 0, 0, 2, 0, 0));

        foreach (rows[r]) begin
            @(posedge clk);
            #1;
            applyId(rows[r].id);
            hold_i  = rows[r].hold;
            flush_i = rows[r].flush;
            expQ.push_back(rows[r]);
            #1;
            rst_n = !rows[r].rst;
        end

        for (int k = 0; k < 10 && expQ.size() != 0; k++) begin
            @(posedge clk);
        end
        if (expQ.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d rows left, required 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_regs.md
Name: ctrl_pipe_regs

Overview:
- Consumer (slave) end of the Control_unit_Intereface control bundle: RegDst, Branch, MemtoReg, ALUOp, MemRead, MemWrite, ALUSrc, RegWrite.
- Carries the decoded control bits from ID through the EX, MEM and WB pipeline registers.
- Detects load-use hazards, inserts bubbles, and applies branch flush and global hold.
- Keeps a saturating count of load-use stall cycles.

Parameters:
- ALUOP_W, 1, width of the ALUOp field.
- REG_AW, 5, register-number width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_RegDst, id_Branch, id_MemtoReg, id_MemRead, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  decoded control bits from the control unit.
- id_ALUOp  in  ALUOP_W  decoded ALU operation.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_AW each  register fields of the ID instruction.
- hold_i  in  1  global freeze (e.g. memory wait).
- flush_i  in  1  branch taken, resolved in MEM.
- stall_o  out  1  load-use stall; IF/ID must hold.
- ex_RegDst, ex_ALUSrc  out  1 each  EX-stage control.
- ex_ALUOp  out  ALUOP_W  EX-stage ALU operation.
- ex_wreg  out  REG_AW  EX destination register.
- mem_Branch, mem_MemRead, mem_MemWrite  out  1 each  MEM-stage control.
- mem_wreg  out  REG_AW  MEM destination register.
- wb_MemtoReg, wb_RegWrite  out  1 each  WB-stage control.
- wb_wreg  out  REG_AW  WB destination register.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset: all stage registers, valid bits, wreg fields and stall_cnt go to 0 asynchronously on rst_n=0. All outputs read 0 while reset is held. Reset asserted mid-operation discards all in-flight instructions.
- Stages: EX, MEM and WB each hold a valid bit plus the control subset still needed downstream.
  - EX holds all 8 control bits.
  - MEM holds Branch, MemRead, MemWrite, MemtoReg, RegWrite.
  - WB holds MemtoReg, RegWrite.
  - A bubble is valid=0 with all control bits 0, so bubbles are never side-effecting.
- Destination register: at ID->EX entry, ex_wreg = id_RegDst ? id_rd : id_rt. wreg then travels unchanged to MEM and WB.
- Hazard (combinational): hazard = ex_valid & ex_MemRead & (ex_wreg!=0) & id_valid & (ex_wreg==id_rs | ex_wreg==id_rt).
  - stall_o = hazard & ~flush_i.
  - stall_o is independent of hold_i. A stall may therefore be visible while frozen.
- Per rising edge, priority highest first:
  1. hold_i=1: every stage keeps its value; stall_cnt unchanged; flush_i ignored.
  2. flush_i=1: EX<=bubble, MEM<=bubble, WB<=old MEM. The ID instruction and the current EX are discarded. stall_cnt unchanged.
  3. hazard=1: EX<=bubble, MEM<=old EX, WB<=old MEM. stall_cnt increments, saturating at all-ones.
  4. otherwise: EX<=ID (bubble if id_valid=0), MEM<=old EX, WB<=old MEM.
- Latency: a valid, unstalled ID instruction appears on ex_* 1 cycle after capture, on mem_* after 2 cycles, and on wb_* after 3 cycles.
- Consecutive hazard cycles: a load followed by a dependent instruction yields exactly one bubble. On the next cycle the load sits in MEM, so the hazard clears.
- Stall counter: stall_cnt=2^CNT_W-1 stays at that value on further stalls. It never wraps.
- Output timing: outputs are registered stage contents, except stall_o, which is combinational.

Test Plan:
- Straight flow: issue an R-type (RegDst=1, RegWrite=1, rd=3) then a 0-valid bubble -> ex_wreg=3 at cycle+1; wb_RegWrite=1 and wb_wreg=3 at cycle+3; the bubble yields all-zero outputs.
- Load-use: lw (MemRead=1, MemtoReg=1, RegWrite=1, RegDst=0, rt=5), then add with rs=5 -> stall_o=1 for exactly one cycle; EX shows a bubble; mem_MemRead=1; add reaches ex_* one cycle later; stall_cnt=1.
- Hazard on $0: lw with rt=0 followed by a user of rs=0 -> stall_o=0; no bubble; stall_cnt=0.
- Flush vs hazard: raise flush_i in the same cycle as a load-use hazard -> stall_o=0; next cycle EX and MEM are bubbles; WB receives the old MEM; stall_cnt unchanged.
- Hold: assert hold_i for 3 cycles with a hazard pending and flush_i pulsed -> all outputs frozen and stall_cnt unchanged; after release, the hazard is serviced normally and the flush is lost.
- Reset and saturation: force stall_cnt to 16'hFFFE, apply 3 hazard cycles -> value reaches 16'hFFFF and stays there. Drop rst_n asynchronously mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
